reset_sequencer: RTL and testbench



---
 rtl/reset_sequencer_pkg.sv | 36 +++
 rtl/reset_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_reset_sequencer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/reset_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reset_sequencer_pkg
// Description : Shared types and sizing helpers for the reset sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package reset_sequencer_pkg;

    // Sequencer phases: hold all resets, wait for a stage's ready, gap before
    // the next release, and fully released.
    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_WAIT = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

    // Width of the single shared counter. It only ever holds values up to
    // (longest interval - 1), so $clog2 of the longest interval suffices.
    function automatic int count_width(input int hold_c,
                                       input int step_c,
                                       input int timeout_c);
        int longest;
        longest = hold_c;
        if (step_c > longest)    longest = step_c;
        if (timeout_c > longest) longest = timeout_c;
        return (longest > 1) ? $clog2(longest) : 1;
    endfunction

    // Width of a stage index (and of the fault_stage output).
    function automatic int index_width(input int stages);
        return (stages > 1) ? $clog2(stages) : 1;
    endfunction

endpackage : reset_sequencer_pkg
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reset_sequencer
// Description : Ordered reset-release sequencer for STAGES downstream
//               domains. All outputs assert together, are held for
//               HOLD_CYCLES, then released one by one, each release gated on
//               the previous domain reporting ready. A stuck domain triggers
//               an automatic retry and raises a sticky timeout flag.
// Revision    : 1.0 - initial release
// ============================================================================
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int   STAGES         = 3,
    parameter int   HOLD_CYCLES    = 16,
    parameter int   STEP_CYCLES    = 8,
    parameter int   TIMEOUT_CYCLES = 1024,
    parameter logic ACTIVE_LEVEL   = 1'b1
) (
    input  logic                                        reset,
    input  logic                                        clk,
    input  logic                                        req,
    input  logic [STAGES-1:0]                           ready,
    output logic [STAGES-1:0]                           rst_out,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        timeout,
    output logic [(STAGES>1 ? $clog2(STAGES) : 1)-1:0]  fault_stage
);

    localparam int CW = count_width(HOLD_CYCLES, STEP_CYCLES, TIMEOUT_CYCLES);
    localparam int IW = index_width(STAGES);

    localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] STEP_LAST    = CW'(STEP_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [IW-1:0] LAST_STAGE   = IW'(STAGES - 1);

    localparam logic [STAGES-1:0] ALL_ASSERTED = {STAGES{ACTIVE_LEVEL}};

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    seq_state_t         state;
    logic [CW-1:0]      count;
    logic [IW-1:0]      stage;

    seq_state_t         state_nxt;
    logic [CW-1:0]      count_nxt;
    logic [IW-1:0]      stage_nxt;
    logic [STAGES-1:0]  rst_out_nxt;
    logic               busy_nxt;
    logic               done_nxt;
    logic               timeout_nxt;
    logic [IW-1:0]      fault_stage_nxt;

    logic [STAGES-1:0]  confirmed;
    logic               confirmed_drop;
    logic               cur_ready;
    logic [IW-1:0]      next_stage;

    assign next_stage = stage + 1'b1;

    // Stages whose ready has already been accepted; losing any of them
    // invalidates the whole sequence. Stages not yet released are ignored.
    always_comb begin
        confirmed = '0;
        for (int j = 0; j < STAGES; j++) begin
            case (state)
                ST_WAIT,
                ST_GAP:  confirmed[j] = (IW'(j) < stage);
                ST_DONE: confirmed[j] = 1'b1;
                default: confirmed[j] = 1'b0;
            endcase
        end
    end

    assign confirmed_drop = |(confirmed & ~ready);

    // Ready bit of the stage currently being waited on.
    always_comb begin
        cur_ready = 1'b0;
        for (int j = 0; j < STAGES; j++) begin
            if (IW'(j) == stage) begin
                cur_ready = ready[j];
            end
        end
    end

    // Next-state logic: progress through HOLD/WAIT/GAP/DONE, with restart
    // taking effect on the same edge as its trigger.
    always_comb begin
        logic restart;

        state_nxt       = state;
        count_nxt       = count;
        stage_nxt       = stage;
        rst_out_nxt     = rst_out;
        busy_nxt        = busy;
        done_nxt        = done;
        timeout_nxt     = timeout;
        fault_stage_nxt = fault_stage;
        restart         = 1'b0;

        if (req) begin
            // Explicit request wins over everything and clears the history.
            restart         = 1'b1;
            timeout_nxt     = 1'b0;
            fault_stage_nxt = '0;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (count == HOLD_LAST) begin
                        rst_out_nxt[0] = ~ACTIVE_LEVEL;
                        stage_nxt      = '0;
                        count_nxt      = '0;
                        state_nxt      = ST_WAIT;
                    end else begin
                        count_nxt = count + 1'b1;
                    end
                end

                ST_WAIT: begin
                    if (!cur_ready && count == TIMEOUT_LAST) begin
                        // Timeout outranks a simultaneous confirmed drop so
                        // the flag records the stuck stage.
                        restart         = 1'b1;
                        timeout_nxt     = 1'b1;
                        fault_stage_nxt = stage;
                    end else if (confirmed_drop) begin
                        restart = 1'b1;
                    end else if (cur_ready) begin
                        count_nxt = '0;
                        if (stage == LAST_STAGE) begin
                            state_nxt = ST_DONE;
                            done_nxt  = 1'b1;
                            busy_nxt  = 1'b0;
                        end else begin
                            state_nxt = ST_GAP;
                        end
                    end else begin
                        count_nxt = count + 1'b1;
                    end
                end

                ST_GAP: begin
                    if (confirmed_drop) begin
                        restart = 1'b1;
                    end else if (count == STEP_LAST) begin
                        for (int j = 0; j < STAGES; j++) begin
                            if (IW'(j) == next_stage) begin
                                rst_out_nxt[j] = ~ACTIVE_LEVEL;
                            end
                        end
                        stage_nxt = next_stage;
                        count_nxt = '0;
                        state_nxt = ST_WAIT;
                    end else begin
                        count_nxt = count + 1'b1;
                    end
                end

                ST_DONE: begin
                    if (confirmed_drop) begin
                        restart = 1'b1;
                    end
                end

                default: begin
                    restart = 1'b1;
                end
            endcase
        end

        if (restart) begin
            rst_out_nxt = ALL_ASSERTED;
            done_nxt    = 1'b0;
            busy_nxt    = 1'b1;
            count_nxt   = '0;
            stage_nxt   = '0;
            state_nxt   = ST_HOLD;
        end
    end

    // Register every output; async reset forces all domains into reset
    // without needing a running clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_HOLD;
            count       <= '0;
            stage       <= '0;
            rst_out     <= ALL_ASSERTED;
            busy        <= 1'b1;
            done        <= 1'b0;
            timeout     <= 1'b0;
            fault_stage <= '0;
        end else begin
            state       <= state_nxt;
            count       <= count_nxt;
            stage       <= stage_nxt;
            rst_out     <= rst_out_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            timeout     <= timeout_nxt;
            fault_stage <= fault_stage_nxt;
        end
    end

endmodule : reset_sequencer
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reset_sequencer
// Description : Scoreboard bench for reset_sequencer (3-stage and 1-stage).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

    typedef struct {
        int         e;
        logic [2:0] r;
        logic       d;
        logic       bz;
        logic       t;
        logic [1:0] f;
        string      nm;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    logic       clk = 1'b0;
    logic       clk_en = 1'b1;
    logic       reset, reset_b;
    logic       req, req_b;
    logic [2:0] ready;
    logic [0:0] ready1;

    logic [2:0] rst_out;
    logic       busy, done, timeout;
    logic [1:0] fault_stage;

    logic [0:0] rst_out1;
    logic       busy1, done1, timeout1;
    logic [0:0] fault_stage1;

    int edges = 0;
    int n_checks = 0;
    int n_pass = 0;
    int b = 0;
    bit b_set = 1'b0;

    reset_sequencer #(
        .STAGES(3), .HOLD_CYCLES(16), .STEP_CYCLES(8),
        .TIMEOUT_CYCLES(64), .ACTIVE_LEVEL(1'b1)
    ) dut (
        .reset(reset), .clk(clk), .req(req), .ready(ready),
        .rst_out(rst_out), .busy(busy), .done(done),
        .timeout(timeout), .fault_stage(fault_stage)
    );

    reset_sequencer #(
        .STAGES(1), .HOLD_CYCLES(16), .STEP_CYCLES(8),
        .TIMEOUT_CYCLES(64), .ACTIVE_LEVEL(1'b1)
    ) dut1 (
        .reset(reset_b), .clk(clk), .req(req_b), .ready(ready1),
        .rst_out(rst_out1), .busy(busy1), .done(done1),
        .timeout(timeout1), .fault_stage(fault_stage1)
    );

    // Gateable clock; phase is preserved while stopped.
    initial begin
        forever begin
            #5;
            if (clk_en) clk = ~clk;
            else        clk = 1'b0;
        end
    end

    always @(posedge clk) edges <= edges + 1;

    function automatic void push0(input int e, input logic [2:0] r, input logic d,
                                  input logic bz, input logic t, input logic [1:0] f,
                                  input string nm);
        exp_t x;
        x.e = e; x.r = r; x.d = d; x.bz = bz; x.t = t; x.f = f; x.nm = nm;
        q0.push_back(x);
    endfunction

    function automatic void push1(input int e, input logic r, input logic d,
                                  input logic bz, input logic t, input string nm);
        exp_t x;
        x.e = e; x.r = {2'b00, r}; x.d = d; x.bz = bz; x.t = t; x.f = 2'b00; x.nm = nm;
        q1.push_back(x);
    endfunction

    task automatic compare(input string nm, input int e,
                           input logic [7:0] got, input logic [7:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s edge=%0d got {rst,done,busy,to,fs}=%b required=%b",
                      nm, e, got, want);
    endtask

    task automatic wait_edge(input int n);
        while (edges < n) @(negedge clk);
    endtask

    // Monitor: samples mid-cycle and retires every expectation due now.
    initial begin
        #2;
        forever begin
            while (q0.size() > 0 && q0[0].e <= edges) begin
                if (q0[0].e < edges) begin
                    n_checks++;
                    $display("FAIL %s expectation for edge %0d not sampled (now %0d)",
                             q0[0].nm, q0[0].e, edges);
                end else begin
                    compare(q0[0].nm, edges,
                            {rst_out, done, busy, timeout, fault_stage},
                            {q0[0].r, q0[0].d, q0[0].bz, q0[0].t, q0[0].f});
                end
                void'(q0.pop_front());
            end
            while (q1.size() > 0 && q1[0].e <= edges) begin
                if (q1[0].e < edges) begin
                    n_checks++;
                    $display("FAIL %s expectation for edge %0d not sampled (now %0d)",
                             q1[0].nm, q1[0].e, edges);
                end else begin
                    compare(q1[0].nm, edges,
                            {2'b00, rst_out1, done1, busy1, timeout1, 1'b0, fault_stage1},
                            {q1[0].r, q1[0].d, q1[0].bz, q1[0].t, q1[0].f});
                end
                void'(q1.pop_front());
            end
            #10;
        end
    end

    // Single-stage instance: release, then timeout with fault_stage 0.
    initial begin
        wait (b_set);
        push1(b + 15,  1'b1, 1'b0, 1'b1, 1'b0, "s6_hold15");
        push1(b + 16,  1'b0, 1'b0, 1'b1, 1'b0, "s6_release");
        push1(b + 17,  1'b0, 1'b1, 1'b0, 1'b0, "s6_done");
        push1(b + 21,  1'b1, 1'b0, 1'b1, 1'b0, "s6_drop_restart");
        push1(b + 37,  1'b0, 1'b0, 1'b1, 1'b0, "s6_rerelease");
        push1(b + 100, 1'b0, 1'b0, 1'b1, 1'b0, "s6_wait63");
        push1(b + 101, 1'b1, 1'b0, 1'b1, 1'b1, "s6_timeout");
        wait_edge(b + 20);
        ready1 = 1'b0;
    end

    // Main stimulus for the three-stage instance.
    initial begin
        int s, t, d, e, r, q, b2;
        reset = 1'b1; reset_b = 1'b1;
        req = 1'b0; req_b = 1'b0;
        ready = 3'b111; ready1 = 1'b1;

        repeat (3) @(negedge clk);
        push0(edges, 3'b111, 1'b0, 1'b1, 1'b0, 2'd0, "reset_state");
        push1(edges, 1'b1,   1'b0, 1'b1, 1'b0,       "s6_reset_state");
        @(negedge clk);
        reset = 1'b0; reset_b = 1'b0;
        b = edges;
        b_set = 1'b1;

        // 1: all ready
        push0(b + 15,  3'b111, 0, 1, 0, 2'd0, "s1_hold15");
        push0(b + 16,  3'b110, 0, 1, 0, 2'd0, "s1_rel0");
        push0(b + 24,  3'b110, 0, 1, 0, 2'd0, "s1_gap0_end");
        push0(b + 25,  3'b100, 0, 1, 0, 2'd0, "s1_rel1");
        push0(b + 33,  3'b100, 0, 1, 0, 2'd0, "s1_gap1_end");
        push0(b + 34,  3'b000, 0, 1, 0, 2'd0, "s1_rel2");
        push0(b + 35,  3'b000, 1, 0, 0, 2'd0, "s1_done");
        push0(b + 135, 3'b000, 1, 0, 0, 2'd0, "s1_stable100");
        push0(b + 235, 3'b000, 1, 0, 0, 2'd0, "s1_stable200");
        wait_edge(b + 236);

        // 2: stage 1 never ready -> timeout, then recover
        s = b + 237;
        t = s + 89;
        push0(s,      3'b111, 0, 1, 0, 2'd0, "s2_req_restart");
        push0(s + 16, 3'b110, 0, 1, 0, 2'd0, "s2_rel0");
        push0(s + 25, 3'b100, 0, 1, 0, 2'd0, "s2_rel1");
        push0(s + 88, 3'b100, 0, 1, 0, 2'd0, "s2_wait63");
        push0(t,      3'b111, 0, 1, 1, 2'd1, "s2_timeout");
        push0(t + 16, 3'b110, 0, 1, 1, 2'd1, "s2_retry_rel0");
        push0(t + 34, 3'b000, 0, 1, 1, 2'd1, "s2_retry_rel2");
        push0(t + 35, 3'b000, 1, 0, 1, 2'd1, "s2_retry_done");
        req = 1'b1; ready = 3'b101;
        wait_edge(s);
        req = 1'b0;
        wait_edge(t + 5);
        ready = 3'b111;
        wait_edge(t + 40);

        // 3: one-cycle drop of confirmed ready[0] after done
        d = t + 41;
        push0(d,      3'b111, 0, 1, 1, 2'd1, "s3_drop_restart");
        push0(d + 15, 3'b111, 0, 1, 1, 2'd1, "s3_hold15");
        push0(d + 16, 3'b110, 0, 1, 1, 2'd1, "s3_rel0");
        push0(d + 25, 3'b100, 0, 1, 1, 2'd1, "s3_rel1");
        push0(d + 34, 3'b000, 0, 1, 1, 2'd1, "s3_rel2");
        push0(d + 35, 3'b000, 1, 0, 1, 2'd1, "s3_done");
        ready = 3'b110;
        wait_edge(d);
        ready = 3'b111;
        wait_edge(d + 40);

        // 4: req pulse during GAP clears the sticky flag
        e = d + 41;
        r = e + 20;
        push0(e + 19, 3'b110, 0, 1, 1, 2'd1, "s4_in_gap");
        push0(r,      3'b111, 0, 1, 0, 2'd0, "s4_req_restart");
        push0(r + 15, 3'b111, 0, 1, 0, 2'd0, "s4_hold15");
        push0(r + 16, 3'b110, 0, 1, 0, 2'd0, "s4_rel0");
        push0(r + 35, 3'b000, 1, 0, 0, 2'd0, "s4_done");
        ready = 3'b110;
        wait_edge(e);
        ready = 3'b111;
        wait_edge(r - 1);
        req = 1'b1;
        wait_edge(r);
        req = 1'b0;
        wait_edge(r + 40);

        // 5: async reset mid-GAP with the clock stopped
        q = r + 41;
        push0(q + 20, 3'b110, 0, 1, 0, 2'd0, "s5_in_gap");
        req = 1'b1;
        wait_edge(q);
        req = 1'b0;
        wait_edge(q + 20);
        clk_en = 1'b0;
        #3 reset = 1'b1;
        #1 push0(edges, 3'b111, 0, 1, 0, 2'd0, "s5_async_reset");
        #36 reset = 1'b0;
        b2 = edges;
        push0(b2 + 15, 3'b111, 0, 1, 0, 2'd0, "s5_hold15");
        push0(b2 + 16, 3'b110, 0, 1, 0, 2'd0, "s5_rel0");
        push0(b2 + 25, 3'b100, 0, 1, 0, 2'd0, "s5_rel1");
        push0(b2 + 34, 3'b000, 0, 1, 0, 2'd0, "s5_rel2");
        push0(b2 + 35, 3'b000, 1, 0, 0, 2'd0, "s5_done");
        #1 clk_en = 1'b1;
        wait_edge(b2 + 40);
        #20;

        if (q0.size() != 0 || q1.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain pending=%0d required=0", q0.size() + q1.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_reset_sequencer
`default_nettype wire
